// File: rtl/soduku_board_loader.sv
// Sudoku board loader: assembles a streamed sequence of BCD cells into the packed
// board bus for the solver, with cursor tracking, backspace, clear and a valid/ack handoff.
module soduku_board_loader #(
  parameter int unsigned GRID_SIZE = 9,
  parameter int unsigned CELL_W    = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [CELL_W-1:0]                     digit_in,
  input  logic                                  digit_valid_in,
  output logic                                  digit_ready_out,
  input  logic                                  back_in,
  input  logic                                  clear_in,
  output logic [CELL_W*GRID_SIZE*GRID_SIZE-1:0] board_out,
  output logic                                  board_valid_out,
  input  logic                                  board_ack_in,
  output logic [3:0]                            row_out,
  output logic [3:0]                            col_out,
  output logic                                  bad_digit_out
);

  localparam int unsigned NCELLS  = GRID_SIZE * GRID_SIZE;
  localparam int unsigned LAST    = NCELLS - 1;
  localparam int unsigned BOARD_W = CELL_W * NCELLS;
  localparam int unsigned CUR_W   = 7;
  localparam int unsigned RC_W    = 4;
  localparam int unsigned IDX_W   = $clog2(BOARD_W);

  typedef enum logic {S_LOAD, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [CUR_W-1:0]     cursor, cursor_nxt;
  logic [BOARD_W-1:0]   board_nxt;
  logic [RC_W-1:0]      row_nxt, col_nxt;
  logic                 valid_nxt, bad_nxt;
  logic                 accept, digit_ok, at_last, at_first;
  logic [IDX_W-1:0]     wr_lsb, bk_lsb;

  assign digit_ready_out = (state == S_LOAD) & ~clear_in & ~back_in;
  assign accept          = digit_valid_in & digit_ready_out;
  assign digit_ok        = (digit_in <= CELL_W'(9));
  assign at_last         = (cursor == CUR_W'(LAST));
  assign at_first        = (cursor == '0);
  // Cell i sits at bits [CELL_W*(LAST-i) +: CELL_W]; backspace targets cell cursor-1.
  assign wr_lsb          = IDX_W'(CELL_W * (LAST - 32'(cursor)));
  assign bk_lsb          = IDX_W'(CELL_W * (NCELLS - 32'(cursor)));

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= S_LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_in) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD: if (accept && digit_ok && at_last) state_nxt = S_DONE;
        S_DONE: if (board_ack_in) state_nxt = S_LOAD;
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  // Next values for the registered board, cursor and status outputs.
  always_comb begin
    board_nxt  = board_out;
    cursor_nxt = cursor;
    row_nxt    = row_out;
    col_nxt    = col_out;
    valid_nxt  = board_valid_out;
    bad_nxt    = 1'b0;
    if (clear_in) begin
      board_nxt  = '0;
      cursor_nxt = '0;
      row_nxt    = '0;
      col_nxt    = '0;
      valid_nxt  = 1'b0;
    end else if (state == S_LOAD) begin
      if (back_in) begin
        if (!at_first) begin
          cursor_nxt                  = cursor - CUR_W'(1);
          board_nxt[bk_lsb +: CELL_W] = '0;
          if (col_out == '0) begin
            col_nxt = RC_W'(GRID_SIZE - 1);
            row_nxt = row_out - RC_W'(1);
          end else begin
            col_nxt = col_out - RC_W'(1);
          end
        end
      end else if (accept) begin
        if (digit_ok) begin
          board_nxt[wr_lsb +: CELL_W] = digit_in;
          if (at_last) begin
            cursor_nxt = '0;
            row_nxt    = '0;
            col_nxt    = '0;
            valid_nxt  = 1'b1;
          end else begin
            cursor_nxt = cursor + CUR_W'(1);
            if (col_out == RC_W'(GRID_SIZE - 1)) begin
              col_nxt = '0;
              row_nxt = row_out + RC_W'(1);
            end else begin
              col_nxt = col_out + RC_W'(1);
            end
          end
        end else begin
          bad_nxt = 1'b1;
        end
      end
    end else if (board_ack_in) begin
      cursor_nxt = '0;
      row_nxt    = '0;
      col_nxt    = '0;
      valid_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      board_out       <= '0;
      cursor          <= '0;
      row_out         <= '0;
      col_out         <= '0;
      board_valid_out <= 1'b0;
      bad_digit_out   <= 1'b0;
    end else begin
      board_out       <= board_nxt;
      cursor          <= cursor_nxt;
      row_out         <= row_nxt;
      col_out         <= col_nxt;
      board_valid_out <= valid_nxt;
      bad_digit_out   <= bad_nxt;
    end
  end

endmodule
